// File: rtl/adc_frame_capture.sv
// -----------------------------------------------------------------------------
// adc_frame_capture
//
// Writer for the waveform RAM that a frame reader scans once per display period.
// It waits for a level crossing on the ADC stream, or forces a start after
// TIMEOUT clocks. It then writes DEPTH consecutive samples to RAM addresses
// 0..DEPTH-1 and raises frame_ready, so the reader only shows complete frames.
//
// Ports
//   clk           system clock
//   rst_n         asynchronous active-low reset
//   adc_data      ADC sample (unsigned, DW bits)
//   adc_valid     single-cycle strobe, adc_data is valid this cycle
//   trig_level    trigger threshold (unsigned, DW bits)
//   trig_falling  0 = rising-edge trigger, 1 = falling-edge trigger
//   arm           pulse that starts a capture; honoured only in IDLE or DONE
//   wr_en         RAM write enable (registered, one cycle per accepted sample)
//   wr_addr       RAM write address (registered, holds when wr_en is low)
//   wr_data       RAM write data (registered)
//   busy          high while waiting for a trigger or capturing
//   done          one-cycle pulse, coincident with the write to DEPTH-1
//   frame_ready   high from done until the next accepted arm
//   auto_trig     the frame was started by timeout; valid while frame_ready
//   state_dbg     current FSM state (IDLE=0, WAIT_TRIG=1, CAPTURE=2, DONE=3)
//
// Handshake: adc_valid is a strobe with no back-pressure. Every strobe seen in
// CAPTURE is written one clock later. arm is a level-sampled pulse. It is
// honoured only in IDLE or DONE, and a new capture never starts while one is
// in progress. DEPTH must be <= 2**AW.
// -----------------------------------------------------------------------------
module adc_frame_capture #(
  parameter int DEPTH   = 2048,
  parameter int AW      = 13,
  parameter int DW      = 10,
  parameter int TIMEOUT = 500_000
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [DW-1:0] adc_data,
  input  logic          adc_valid,
  input  logic [DW-1:0] trig_level,
  input  logic          trig_falling,
  input  logic          arm,
  output logic          wr_en,
  output logic [AW-1:0] wr_addr,
  output logic [DW-1:0] wr_data,
  output logic          busy,
  output logic          done,
  output logic          frame_ready,
  output logic          auto_trig,
  output logic [1:0]    state_dbg
);

  localparam int            TW        = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [AW-1:0] LAST_ADDR = AW'(DEPTH - 1);
  localparam logic [TW-1:0] TO_LAST   = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_CAPT = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t        state,       state_nx;
  logic [DW-1:0] prev_sample, prev_sample_nx;
  logic          prev_valid,  prev_valid_nx;
  logic [TW-1:0] tcnt,        tcnt_nx;
  logic [AW-1:0] next_addr,   next_addr_nx;
  logic          wr_en_nx;
  logic [AW-1:0] wr_addr_nx;
  logic [DW-1:0] wr_data_nx;
  logic          done_nx;
  logic          frame_ready_nx;
  logic          auto_trig_nx;

  // Crossing detection. A crossing needs a previous valid sample. That sample
  // must lie strictly on the far side of the level, and the new one must
  // reach or pass it. So a level of 0 with a rising edge can never fire.
  logic rise_hit;
  logic fall_hit;
  logic trig_hit;

  assign rise_hit = prev_valid && (prev_sample < trig_level) && (adc_data >= trig_level);
  assign fall_hit = prev_valid && (prev_sample > trig_level) && (adc_data <= trig_level);
  assign trig_hit = adc_valid && (trig_falling ? fall_hit : rise_hit);

  always_comb begin
    state_nx       = state;
    prev_sample_nx = prev_sample;
    prev_valid_nx  = prev_valid;
    tcnt_nx        = tcnt;
    next_addr_nx   = next_addr;
    wr_en_nx       = 1'b0;
    wr_addr_nx     = wr_addr;
    wr_data_nx     = wr_data;
    done_nx        = 1'b0;
    frame_ready_nx = frame_ready;
    auto_trig_nx   = auto_trig;

    case (state)
      S_IDLE, S_DONE: begin
        if (arm) begin
          // Entering WAIT_TRIG: forget the old history and the old frame status.
          state_nx       = S_WAIT;
          prev_valid_nx  = 1'b0;
          tcnt_nx        = '0;
          frame_ready_nx = 1'b0;
          auto_trig_nx   = 1'b0;
        end
      end

      S_WAIT: begin
        tcnt_nx = tcnt + 1'b1;
        if (adc_valid) begin
          prev_sample_nx = adc_data;
          prev_valid_nx  = 1'b1;
        end
        if (trig_hit) begin
          // The trigger sample itself is the first sample of the frame.
          // A trigger beats a timeout that lands in the same cycle.
          wr_en_nx   = 1'b1;
          wr_addr_nx = '0;
          wr_data_nx = adc_data;
          if (LAST_ADDR == '0) begin
            state_nx       = S_DONE;
            done_nx        = 1'b1;
            frame_ready_nx = 1'b1;
          end else begin
            state_nx     = S_CAPT;
            next_addr_nx = AW'(1);
          end
        end else if (tcnt == TO_LAST) begin
          // Forced start: nothing is written now; the next strobe lands at 0.
          state_nx     = S_CAPT;
          auto_trig_nx = 1'b1;
          next_addr_nx = '0;
        end
      end

      S_CAPT: begin
        if (adc_valid) begin
          wr_en_nx   = 1'b1;
          wr_addr_nx = next_addr;
          wr_data_nx = adc_data;
          if (next_addr == LAST_ADDR) begin
            // Final write. The FSM leaves CAPTURE, so later strobes are never written.
            state_nx       = S_DONE;
            done_nx        = 1'b1;
            frame_ready_nx = 1'b1;
          end else begin
            next_addr_nx = next_addr + 1'b1;
          end
        end
      end

      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= S_IDLE;
      prev_sample <= '0;
      prev_valid  <= 1'b0;
      tcnt        <= '0;
      next_addr   <= '0;
      wr_en       <= 1'b0;
      wr_addr     <= '0;
      wr_data     <= '0;
      done        <= 1'b0;
      frame_ready <= 1'b0;
      auto_trig   <= 1'b0;
    end else begin
      state       <= state_nx;
      prev_sample <= prev_sample_nx;
      prev_valid  <= prev_valid_nx;
      tcnt        <= tcnt_nx;
      next_addr   <= next_addr_nx;
      wr_en       <= wr_en_nx;
      wr_addr     <= wr_addr_nx;
      wr_data     <= wr_data_nx;
      done        <= done_nx;
      frame_ready <= frame_ready_nx;
      auto_trig   <= auto_trig_nx;
    end
  end

  assign busy      = (state == S_WAIT) || (state == S_CAPT);
  assign state_dbg = state;

endmodule
